// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding, the default payload
// width and the line idle level. Imported by the transmit engine.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable baud-rate divider counter.
// Counts 0..div and emits a one-cycle tick on the clock where the count
// equals div, then wraps to 0. While restart is high the count is held at 0
// and no tick is produced, so the first tick after restart drops arrives
// div+1 clocks later.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   restart  hold/clear the counter (asserted outside timed states)
//   div      divider value; period = div+1 clocks
//   tick     end-of-period strobe
module uart_baud_gen #(
  parameter int DIV_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] baud_cnt;

  // Gating with restart keeps tick quiet while div is not yet meaningful.
  assign tick = !restart && (baud_cnt == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
    end else if (restart || tick) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops bytes from the TX FIFO while transmit is enabled
// and serialises each one as a start bit, DATA_BITS payload bits (LSB first)
// and STOP_BITS stop bits, each bit lasting baud_div+1 clocks.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset (aborts any frame in flight)
//   tx_en_i       transmit enable, sampled only in IDLE
//   fifo_empty_i  TX FIFO empty flag, sampled only in IDLE
//   fifo_data_i   TX FIFO read data, valid the cycle after fifo_rd_en_o
//   fifo_rd_en_o  single-cycle FIFO pop strobe
//   baud_div_i    baud divider, latched once per frame
//   txd_o         registered serial output, idle high
//   busy_o        high from POP through the last stop bit
//   frame_done_o  one-cycle pulse after the final stop bit
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int STOP_BITS = 1,
  parameter int DIV_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_en_i,
  input  logic                 fifo_empty_i,
  input  logic [DATA_BITS-1:0] fifo_data_i,
  output logic                 fifo_rd_en_o,
  input  logic [DIV_WIDTH-1:0] baud_div_i,
  output logic                 txd_o,
  output logic                 busy_o,
  output logic                 frame_done_o
);

  // One counter serves both payload bits and stop bits.
  localparam int CNT_W = $clog2(DATA_BITS + STOP_BITS);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 txd_q, txd_d;
  logic                 rd_en_q;
  logic                 busy_q;
  logic                 done_q, done_d;
  logic                 tick;
  logic                 restart;

  // The baud counter only runs in the timed states; holding it at 0 before
  // START guarantees the start bit gets a full period. Every later state
  // change happens on a tick, where the counter wraps to 0 by itself.
  assign restart = (state_q == IDLE) || (state_q == POP) || (state_q == LOAD);

  uart_baud_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .div     (div_q),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    div_d     = div_q;
    done_d    = 1'b0;
    txd_d     = UART_IDLE_LEVEL;

    case (state_q)
      IDLE: begin
        if (tx_en_i && !fifo_empty_i) begin
          state_d = POP;
        end
      end
      POP: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d   = fifo_data_i;
        div_d     = baud_div_i;
        bit_cnt_d = '0;
        state_d   = START;
      end
      START: begin
        if (tick) begin
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = '0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Pad level is derived from where the FSM is going, so the registered
    // output lines up with the state register.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      txd_q     <= UART_IDLE_LEVEL;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
      rd_en_q   <= (state_d == POP);
      busy_q    <= (state_d != IDLE);
      done_q    <= done_d;
    end
  end

  // Payload and divider are only consumed after LOAD writes them.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    div_q   <= div_d;
  end

  assign fifo_rd_en_o = rd_en_q;
  assign txd_o        = txd_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_en;
  logic        fifo_empty;
  logic [7:0]  fifo_data = '0;
  logic        fifo_rd_en;
  logic [31:0] baud_div;
  logic        txd;
  logic        busy;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  // Bench-side FIFO: initial block owns writes, the always block owns pops.
  logic [7:0] mem [0:255];
  logic [7:0] rd_ptr = '0;
  logic [7:0] wr_ptr = '0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  always #5 clk = ~clk;

  uart_tx_engine #(
    .DATA_BITS (8),
    .STOP_BITS (1),
    .DIV_WIDTH (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_en_i      (tx_en),
    .fifo_empty_i (fifo_empty),
    .fifo_data_i  (fifo_data),
    .fifo_rd_en_o (fifo_rd_en),
    .baud_div_i   (baud_div),
    .txd_o        (txd),
    .busy_o       (busy),
    .frame_done_o (frame_done)
  );

  typedef struct {
    logic [7:0] data;
    int         div;
    logic [9:0] bits;  // line levels in send order, bits[9] first
    string      name;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr      = wr_ptr + 8'd1;
  endtask

  // Call right after the negedge on which the request became visible (or
  // right after the frame_done sample of a previous frame). evt_kind 1 sets
  // baud_div to new_div and evt_kind 2 drops tx_en, at the start of slot evt_bit.
  task automatic expect_frame(input logic [9:0] bits, input int div, input string name,
                              input int evt_bit, input int evt_kind, input int new_div);
    int errs;
    @(negedge clk);
    chk($sformatf("%s_pop", name), {29'd0, fifo_rd_en, busy, txd}, 32'b111);
    @(negedge clk);
    chk($sformatf("%s_load", name), {28'd0, fifo_rd_en, busy, txd, frame_done}, 32'b0110);
    for (int b = 0; b < 10; b++) begin
      errs = 0;
      for (int c = 0; c <= div; c++) begin
        @(negedge clk);
        if (txd !== bits[9-b] || busy !== 1'b1 || frame_done !== 1'b0 || fifo_rd_en !== 1'b0)
          errs++;
        if (b == evt_bit && c == 0) begin
          if (evt_kind == 1) baud_div = new_div;
          if (evt_kind == 2) tx_en = 1'b0;
        end
      end
      chk($sformatf("%s_slot%0d_bad_samples", name, b), errs, 0);
    end
    @(negedge clk);
    chk($sformatf("%s_done", name), {29'd0, frame_done, busy, txd}, 32'b101);
  endtask

  initial begin
    int         errs;
    logic [7:0] saved_ptr;

    vecs[0] = '{8'h55, 3, 10'b0101010101, "v55_div3"};
    vecs[1] = '{8'hFF, 0, 10'b0111111111, "vFF_div0"};
    vecs[2] = '{8'h80, 1, 10'b0000000011, "v80_div1"};
    vecs[3] = '{8'h01, 2, 10'b0100000001, "v01_div2"};

    rst_n    = 1'b0;
    tx_en    = 1'b0;
    baud_div = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {28'd0, txd, fifo_rd_en, busy, frame_done}, 32'b1000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_idle", {28'd0, txd, fifo_rd_en, busy, frame_done}, 32'b1000);

    // Table of single frames.
    for (int i = 0; i < 4; i++) begin
      push(vecs[i].data);
      baud_div = vecs[i].div;
      tx_en    = 1'b1;
      expect_frame(vecs[i].bits, vecs[i].div, vecs[i].name, -1, 0, 0);
      tx_en = 1'b0;
      chk($sformatf("%s_single_pop", vecs[i].name), {24'd0, rd_ptr}, {24'd0, wr_ptr});
      repeat (2) @(negedge clk);
    end

    // Back-to-back frames at div=0: the gap is the POP and LOAD slots plus
    // the IDLE cycle carrying frame_done, all checked high by expect_frame.
    push(8'hA3);
    push(8'h0F);
    baud_div = 32'd0;
    tx_en    = 1'b1;
    expect_frame(10'b0110001011, 0, "b2b_A3", -1, 0, 0);
    expect_frame(10'b0111100001, 0, "b2b_0F", -1, 0, 0);
    tx_en = 1'b0;
    repeat (2) @(negedge clk);

    // Enable low with data waiting: nothing may move for 100 clocks.
    push(8'h3C);
    baud_div  = 32'd1;
    saved_ptr = rd_ptr;
    errs      = 0;
    repeat (100) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) errs++;
    end
    chk("noen_idle_bad_samples", errs, 0);
    chk("noen_ptr", {24'd0, rd_ptr}, {24'd0, saved_ptr});
    tx_en = 1'b1;
    expect_frame(10'b0001111001, 1, "noen_3C", -1, 0, 0);
    tx_en = 1'b0;
    repeat (2) @(negedge clk);

    // Divider change in data bit 2 only affects the following frame.
    push(8'hC6);
    push(8'h2B);
    baud_div = 32'd3;
    tx_en    = 1'b1;
    expect_frame(10'b0011000111, 3, "divchg_C6", 3, 1, 7);
    expect_frame(10'b0110101001, 7, "divchg_2B", -1, 0, 0);
    tx_en = 1'b0;
    repeat (2) @(negedge clk);

    // Enable dropped in data bit 4 with two bytes queued.
    push(8'h96);
    push(8'h5A);
    baud_div  = 32'd1;
    saved_ptr = rd_ptr;
    tx_en     = 1'b1;
    expect_frame(10'b0011010011, 1, "endrop_96", 5, 2, 0);
    errs = 0;
    repeat (20) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) errs++;
    end
    chk("endrop_no_second_pop", errs, 0);
    chk("endrop_ptr", {24'd0, rd_ptr}, {24'd0, 8'(saved_ptr + 8'd1)});

    // Reset during data bit 5 of the queued 0x5A (bit 5 drives a 0).
    tx_en = 1'b1;
    repeat (15) @(negedge clk);
    chk("rst_mid_bit5_level", {30'd0, txd, busy}, 32'b01);
    rst_n = 1'b0;
    tx_en = 1'b0;
    #1;
    chk("rst_async_outputs", {28'd0, txd, busy, fifo_rd_en, frame_done}, 32'b1000);
    saved_ptr = rd_ptr;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    errs  = 0;
    repeat (5) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || txd !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) errs++;
    end
    chk("rst_release_idle", errs, 0);
    chk("rst_ptr_unchanged", {24'd0, rd_ptr}, {24'd0, saved_ptr});
    chk("rst_byte_consumed", {31'd0, fifo_empty}, 32'd1);

    // A fresh frame after reset starts with normal IDLE latency.
    push(8'hE1);
    baud_div = 32'd2;
    tx_en    = 1'b1;
    expect_frame(10'b0100001111, 2, "post_rst_E1", -1, 0, 0);
    tx_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
